// File: rtl/act_mem_pkg.sv
// Shared types and sizing for the MPU allocation control table.
package act_mem_pkg;

  localparam int BLOCK_COUNT      = 64;
  localparam int BLOCK_COUNT_BITS = $clog2(BLOCK_COUNT);
  localparam int OWNER_BITS       = 4;
  localparam int RES_ID_BITS      = 8;
  localparam int MASK_BITS        = 16;

  typedef logic [BLOCK_COUNT_BITS-1:0] addr_t;

  // Mask bit i grants master i read/write permission on the block.
  typedef struct packed {
    logic                   valid;
    logic [MASK_BITS-1:0]   read_mask;
    logic [MASK_BITS-1:0]   write_mask;
    logic [OWNER_BITS-1:0]  owner;
    logic [RES_ID_BITS-1:0] reservation_id;
  } entry_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/act_mem_if.sv
// Access bus for the ACT: malloc and dealloc ports, shared chip select and busy flag.
interface act_mem_if
  import act_mem_pkg::*;
();

  logic   cs;
  logic   malloc_dealloc;
  logic   malloc_we;
  entry_t malloc_wdata;
  addr_t  malloc_addr;
  logic   dealloc_we;
  entry_t dealloc_wdata;
  addr_t  dealloc_addr;
  entry_t malloc_rdata;
  entry_t dealloc_rdata;
  logic   bsy;

  modport master (
    output cs, malloc_dealloc,
    output malloc_we, malloc_wdata, malloc_addr,
    output dealloc_we, dealloc_wdata, dealloc_addr,
    input  malloc_rdata, dealloc_rdata, bsy
  );

  modport slave (
    input  cs, malloc_dealloc,
    input  malloc_we, malloc_wdata, malloc_addr,
    input  dealloc_we, dealloc_wdata, dealloc_addr,
    output malloc_rdata, dealloc_rdata, bsy
  );

endinterface

// File: rtl/act_mem.sv
// ACT storage: one entry per block, one write per cycle from the selected port,
// two combinational read ports, and a reset-time clear engine that holds bsy high.
module act_mem
  import act_mem_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  act_mem_if.slave  bus
);

  state_e state_q;
  addr_t  ptr_q;
  logic   bsy_q;

  entry_t act_mem [0:BLOCK_COUNT-1];

  logic   wr_en;
  addr_t  wr_addr;
  entry_t wr_data;

  // malloc_dealloc steers the single write slot; the other port's we is ignored.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.malloc_addr;
    wr_data = bus.malloc_wdata;
    if (bus.malloc_dealloc) begin
      wr_en   = bus.dealloc_we;
      wr_addr = bus.dealloc_addr;
      wr_data = bus.dealloc_wdata;
    end else begin
      wr_en   = bus.malloc_we;
    end
    wr_en = wr_en & bus.cs & (state_q == IDLE) & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      bsy_q   <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == addr_t'(BLOCK_COUNT - 1)) begin
            state_q <= IDLE;
            bsy_q   <= 1'b0;
          end
        end
        IDLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          bsy_q   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        act_mem[ptr_q] <= '0;
      end else if (wr_en) begin
        act_mem[wr_addr] <= wr_data;
      end
    end
  end

  // Reads see pre-edge contents, so a same-cycle write shows up only after the edge.
  assign bus.malloc_rdata  = bsy_q ? '0 : act_mem[bus.malloc_addr];
  assign bus.dealloc_rdata = bsy_q ? '0 : act_mem[bus.dealloc_addr];
  assign bus.bsy           = bsy_q;

endmodule

// File: tb/tb_act_mem.sv
// Directed plus randomized bench for act_mem against an array/counter reference model.
module tb_act_mem;
  import act_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  act_mem_if bus ();
  act_mem dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  entry_t model [BLOCK_COUNT];
  int     busy_left   = 0;
  bit     model_known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t rand_entry();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return entry_t'(t[$bits(entry_t)-1:0]);
  endfunction

  // One clock: drive at negedge, check reads before the edge, advance the model after it.
  task automatic cycle(input logic r, input logic c, input logic md,
                       input logic mwe, input entry_t mwd, input addr_t ma,
                       input logic dwe, input entry_t dwd, input addr_t da);
    rst                = r;
    bus.cs             = c;
    bus.malloc_dealloc = md;
    bus.malloc_we      = mwe;
    bus.malloc_wdata   = mwd;
    bus.malloc_addr    = ma;
    bus.dealloc_we     = dwe;
    bus.dealloc_wdata  = dwd;
    bus.dealloc_addr   = da;
    #1;
    if (model_known) begin
      check("bsy", bus.bsy, busy_left > 0);
      check("malloc_rdata", bus.malloc_rdata, (busy_left > 0) ? entry_t'('0) : model[ma]);
      check("dealloc_rdata", bus.dealloc_rdata, (busy_left > 0) ? entry_t'('0) : model[da]);
    end
    @(posedge clk);
    if (r) begin
      busy_left   = BLOCK_COUNT;
      model_known = 1'b1;
      foreach (model[i]) model[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (c && (md ? dwe : mwe)) begin
      if (md) model[da] = dwd;
      else    model[ma] = mwd;
    end
    @(negedge clk);
  endtask

  task automatic idle(input addr_t ma, input addr_t da);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, ma, 1'b0, '0, da);
  endtask

  // Counts cycles with bsy high; optionally hammers writes to address 0 meanwhile.
  task automatic count_busy(input bit do_wr, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.bsy !== 1'b1) break;
      n++;
      cycle(1'b0, do_wr, 1'b0, do_wr, entry_t'(45'h1F_FFFF_FFFF), '0, 1'b0, '0, '0);
    end
  endtask

  entry_t d5, d10, dx;
  int     n;
  int     cnt;

  initial begin
    rst = 1'b0;
    bus.cs = 1'b0; bus.malloc_dealloc = 1'b0;
    bus.malloc_we = 1'b0; bus.malloc_wdata = '0; bus.malloc_addr = '0;
    bus.dealloc_we = 1'b0; bus.dealloc_wdata = '0; bus.dealloc_addr = '0;
    d5  = '{1'b1, 16'h000F, 16'hF000, 4'd3, 8'd5};
    d10 = '{1'b1, 16'hFFFF, 16'h0000, 4'd7, 8'd10};
    dx  = '{1'b1, 16'hA5A5, 16'h5A5A, 4'd9, 8'd77};
    @(negedge clk);

    // Reset clear: bsy high for exactly BLOCK_COUNT cycles, then every entry zero.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    check("reset_bsy", bus.bsy, 1'b1);
    check("reset_malloc_rdata", bus.malloc_rdata, '0);
    count_busy(1'b0, n);
    check("clear_len", n, 64);
    cnt = 0;
    for (int i = 0; i < BLOCK_COUNT; i++) if (dut.act_mem[i] !== '0) cnt++;
    check("cleared_entries_nonzero", cnt, 0);

    // malloc write then read back.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, d5, 6'd5, 1'b0, '0, 6'd0);
    check("malloc_wr_rd5", bus.malloc_rdata, d5);

    // dealloc write leaves addr 5 alone.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 6'd5, 1'b1, d10, 6'd10);
    check("dealloc_wr_rd10", bus.dealloc_rdata, d10);
    check("entry5_kept", dut.act_mem[5], d5);
    check("malloc_rd5_concurrent", bus.malloc_rdata, d5);

    // Non-selected port and cs=0 must not write.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, dx, 6'd20, 1'b0, '0, 6'd21);
    check("unselected_malloc_we", dut.act_mem[20], '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, dx, 6'd30, 1'b1, dx, 6'd31);
    check("cs0_malloc", dut.act_mem[30], '0);
    check("cs0_dealloc", dut.act_mem[31], '0);

    cnt = 0;
    for (int i = 0; i < BLOCK_COUNT; i++) if (dut.act_mem[i].valid === 1'b1) cnt++;
    check("valid_count", cnt, 2);
    check("valid5", dut.act_mem[5].valid, 1'b1);
    check("valid10", dut.act_mem[10].valid, 1'b1);

    // Writes during clear are dropped; rst mid-clear restarts the full count.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 20; k++)
      cycle(1'b0, 1'b1, 1'b0, 1'b1, dx, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    count_busy(1'b1, n);
    check("restart_clear_len", n, 64);
    check("busy_write_dropped", dut.act_mem[0], '0);
    check("post_clear_entry5", dut.act_mem[5], '0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 500; k++) begin
      addr_t ma, da;
      ma = ($urandom_range(0, 1) == 0) ? addr_t'($urandom_range(0, 7)) : addr_t'($urandom);
      da = ($urandom_range(0, 1) == 0) ? addr_t'($urandom_range(0, 7)) : addr_t'($urandom);
      cycle(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom),
            1'($urandom), rand_entry(), ma, 1'($urandom), rand_entry(), da);
    end
    count_busy(1'b0, n);
    cnt = 0;
    for (int i = 0; i < BLOCK_COUNT; i++) if (dut.act_mem[i] !== model[i]) cnt++;
    check("final_dump_diffs", cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
